// File: rtl/reflet_mem_rmw_pkg.sv
// Shared encodings for the reflet memory sequencer: access size codes, FSM states
// and the helpers that decide whether an access is narrower than the RAM word.
package reflet_mem_rmw_pkg;

  typedef enum logic [1:0] {
    SIZE_FULL = 2'b00,
    SIZE_32   = 2'b01,
    SIZE_16   = 2'b10,
    SIZE_8    = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } state_e;

  function automatic int size_width(input logic [1:0] size);
    case (size)
      SIZE_32: return 32;
      SIZE_16: return 16;
      SIZE_8:  return 8;
      default: return 0;
    endcase
  endfunction

  // Fetches and sizes at least as wide as the word collapse to a plain full access.
  function automatic logic is_reduced(input logic [1:0] size, input logic fetch,
                                      input int word_bits);
    return (size != SIZE_FULL) && (size_width(size) < word_bits) && !fetch;
  endfunction

endpackage

// File: rtl/reflet_lane_merge.sv
// Combinational lane logic: splices new low bits into an old word for stores and
// zero-extends the low bits of a word for loads.
module reflet_lane_merge
  import reflet_mem_rmw_pkg::*;
#(
  parameter int wordsize = 16
) (
  input  logic [1:0]          size,
  input  logic                reduced,
  input  logic [wordsize-1:0] old_word,
  input  logic [wordsize-1:0] new_word,
  output logic [wordsize-1:0] merged_word,
  output logic [wordsize-1:0] masked_word
);

  logic [wordsize-1:0] lane_mask;

  always_comb begin
    lane_mask = '1;
    if (reduced) begin
      for (int i = 0; i < wordsize; i++) begin
        lane_mask[i] = (i < size_width(size));
      end
    end
  end

  assign merged_word = (old_word & ~lane_mask) | (new_word & lane_mask);
  assign masked_word = old_word & lane_mask;

endmodule

// File: rtl/reflet_mem_rmw.sv
// Memory access sequencer: turns CPU loads/stores into fixed-latency RAM cycles,
// doing read-modify-write for narrow stores and zero-extension for narrow loads.
module reflet_mem_rmw
  import reflet_mem_rmw_pkg::*;
#(
  parameter int wordsize    = 16,
  parameter int ram_latency = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_write,
  input  logic                cpu_fetch,
  input  logic [1:0]          cpu_size,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  output logic [wordsize-1:0] cpu_rdata,
  output logic                cpu_ready,
  output logic                ram_en,
  output logic                ram_we,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_wdata,
  input  logic [wordsize-1:0] ram_rdata
);

  localparam int              CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ram_latency - 1);

  state_e              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                write_q, write_d;
  logic                reduced_q, reduced_d;
  logic [wordsize-1:0] addr_q, addr_d;
  logic [wordsize-1:0] wdata_q, wdata_d;
  logic [wordsize-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [wordsize-1:0] merged_word, masked_word;

  reflet_lane_merge #(.wordsize(wordsize)) u_lane_merge (
    .size        (size_q),
    .reduced     (reduced_q),
    .old_word    (ram_rdata),
    .new_word    (wdata_q),
    .merged_word (merged_word),
    .masked_word (masked_word)
  );

  // wdata_q starts as the store data and is overwritten by the merged word,
  // so it serves as both the latched input and the RMW merge buffer.
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    write_d   = write_q;
    reduced_d = reduced_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    cpu_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          size_d    = cpu_size;
          write_d   = cpu_write;
          reduced_d = is_reduced(cpu_size, cpu_fetch, wordsize);
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          state_d   = (cpu_write && !reduced_d) ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        ram_en  = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            wdata_d = merged_word;
            state_d = ST_WR;
          end else begin
            rdata_d = masked_word;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        cpu_ready = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      size_q    <= SIZE_FULL;
      write_q   <= 1'b0;
      reduced_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      write_q   <= write_d;
      reduced_q <= reduced_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_reflet_mem_rmw.sv
// Scoreboard bench: three sequencers (latency 1, 2, 4) each with a RAM model;
// stimulus queues expected RAM cycles and completions, a monitor pops and compares.
module tb_reflet_mem_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [3];
  logic        cpu_write = 1'b0;
  logic        cpu_fetch = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [15:0] cpu_addr = 16'h0;
  logic [15:0] cpu_wdata = 16'h0;
  logic [15:0] cpu_rdata [3];
  logic        cpu_ready [3];
  logic        ram_en [3];
  logic        ram_we [3];
  logic [15:0] ram_addr [3];
  logic [15:0] ram_wdata [3];
  logic [15:0] ram_rdata [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_seen = 0;
  logic [63:0] ram_q [$];
  logic [63:0] rdy_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [15:0] mem [256];
    logic [15:0] pipe [LAT];
    bit          init_done = 1'b0;

    reflet_mem_rmw #(.wordsize(16), .ram_latency(LAT)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .cpu_req   (req[g]),
      .cpu_write (cpu_write),
      .cpu_fetch (cpu_fetch),
      .cpu_size  (cpu_size),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_ready (cpu_ready[g]),
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g])
    );

    assign ram_rdata[g] = pipe[LAT-1];

    // Word RAM whose read data emerges LAT cycles after the read-enabled cycle.
    always @(posedge clk) begin
      if (!init_done) begin
        for (int k = 0; k < 256; k++) mem[k] <= 16'h0000;
        mem[8'h40] <= 16'hBEEF;
        mem[8'h10] <= 16'hA5C3;
        mem[8'h20] <= 16'hA5C3;
        mem[8'h30] <= 16'h1234;
        init_done  <= 1'b1;
      end
      for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      if (ram_en[g] && !ram_we[g]) pipe[0] <= mem[ram_addr[g][7:0]];
      else                         pipe[0] <= 16'hDEAD;
      if (ram_en[g] && ram_we[g]) mem[ram_addr[g][7:0]] <= ram_wdata[g];
    end
  end

  function automatic void checkOutput(input string name, input logic [63:0] actual,
                                      input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endfunction

  // Every RAM cycle and every completion pulse must match the head of its queue.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ram_en[d]) begin
        checkOutput("ram_cycle_expected", 64'(ram_q.size() != 0), 64'd1);
        if (ram_q.size() != 0)
          checkOutput("ram_cycle", {8'(d), 16'(cyc), 8'(ram_we[d]), ram_addr[d],
                                    ram_we[d] ? ram_wdata[d] : 16'h0}, ram_q.pop_front());
      end
      if (cpu_ready[d]) begin
        ready_seen++;
        checkOutput("ready_expected", 64'(rdy_q.size() != 0), 64'd1);
        if (rdy_q.size() != 0)
          checkOutput("ready_rdata", {16'h0, 8'(d), 16'(cyc), cpu_rdata[d]}, rdy_q.pop_front());
      end
    end
  end

  // Offsets are cycles after the acceptance edge; 0 means that event must not occur.
  task automatic applyStimulus(input int d, input bit wr, input bit fetch,
                               input logic [1:0] size, input logic [15:0] addr,
                               input logic [15:0] wdata, input int rd_off, input int wr_off,
                               input int rdy_off, input logic [15:0] exp_wdata,
                               input logic [15:0] exp_rdata);
    int n;
    int target;
    @(negedge clk);
    n = cyc;
    cpu_write = wr;
    cpu_fetch = fetch;
    cpu_size  = size;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    req[d]    = 1'b1;
    if (rd_off > 0) ram_q.push_back({8'(d), 16'(n + rd_off), 8'h0, addr, 16'h0});
    if (wr_off > 0) ram_q.push_back({8'(d), 16'(n + wr_off), 8'h1, addr, exp_wdata});
    if (rdy_off > 0) rdy_q.push_back({16'h0, 8'(d), 16'(n + rdy_off), exp_rdata});
    target = ready_seen + ((rdy_off > 0) ? 1 : 0);
    @(negedge clk);
    req[d]    = 1'b0;
    cpu_write = ~wr;
    cpu_fetch = ~fetch;
    cpu_size  = ~size;
    cpu_addr  = ~addr;
    cpu_wdata = ~wdata;
    for (int i = 0; i < 40 && ready_seen < target; i++) @(negedge clk);
    checkOutput("ready_arrived", 64'(ready_seen >= target), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 3; d++) req[d] = 1'b0;
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      checkOutput("reset_state", {12'h0, ram_addr[d], ram_wdata[d], cpu_rdata[d],
                                  1'b0, cpu_ready[d], ram_en[d], ram_we[d]}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    //             d  wr fe size   addr     wdata    rd wr rdy exp_wdata exp_rdata
    applyStimulus(1, 0, 0, 2'b00, 16'h0040, 16'h0000, 1, 0, 4, 16'h0000, 16'hBEEF);
    applyStimulus(1, 1, 0, 2'b11, 16'h0010, 16'h1277, 1, 4, 5, 16'hA577, 16'hBEEF);
    applyStimulus(1, 0, 0, 2'b11, 16'h0020, 16'h0000, 1, 0, 4, 16'h0000, 16'h00C3);
    applyStimulus(1, 0, 0, 2'b01, 16'h0020, 16'h0000, 1, 0, 4, 16'h0000, 16'hA5C3);
    applyStimulus(1, 0, 1, 2'b11, 16'h0030, 16'h0000, 1, 0, 4, 16'h0000, 16'h1234);
    applyStimulus(1, 1, 0, 2'b00, 16'h0050, 16'h5678, 0, 1, 2, 16'h5678, 16'h1234);
    applyStimulus(1, 0, 0, 2'b10, 16'h0010, 16'h0000, 1, 0, 4, 16'h0000, 16'hA577);
    applyStimulus(1, 1, 0, 2'b10, 16'h0050, 16'h9ABC, 0, 1, 2, 16'h9ABC, 16'hA577);
    applyStimulus(1, 0, 0, 2'b11, 16'h0050, 16'h0000, 1, 0, 4, 16'h0000, 16'h00BC);
    applyStimulus(0, 1, 0, 2'b11, 16'h0010, 16'h1277, 1, 3, 4, 16'hA577, 16'h0000);
    applyStimulus(0, 0, 0, 2'b00, 16'h0010, 16'h0000, 1, 0, 3, 16'h0000, 16'hA577);
    applyStimulus(2, 1, 0, 2'b11, 16'h0010, 16'h1277, 1, 6, 7, 16'hA577, 16'h0000);
    applyStimulus(2, 0, 0, 2'b11, 16'h0010, 16'h0000, 1, 0, 6, 16'h0000, 16'h0077);

    // Reset while a read-modify-write waits for read data: no write, no completion.
    @(negedge clk);
    n = cyc;
    cpu_write = 1'b1; cpu_fetch = 1'b0; cpu_size = 2'b11;
    cpu_addr = 16'h0020; cpu_wdata = 16'h9999; req[1] = 1'b1;
    ram_q.push_back({8'd1, 16'(n + 1), 8'h0, 16'h0020, 16'h0});
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_wait_ram", 64'({ram_en[1], ram_we[1], cpu_ready[1]}), 64'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset_wait_regs", 64'({ram_addr[1], ram_wdata[1], cpu_rdata[1]}), 64'h0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 2'b00, 16'h0020, 16'h0000, 1, 0, 4, 16'h0000, 16'hA5C3);

    // Reset in the middle of a write cycle must drop the enables at once.
    @(negedge clk);
    cpu_write = 1'b1; cpu_fetch = 1'b0; cpu_size = 2'b00;
    cpu_addr = 16'h0020; cpu_wdata = 16'h1111; req[1] = 1'b1;
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    checkOutput("wr_cycle_active", 64'({ram_en[1], ram_we[1]}), 64'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_wr_ram", 64'({ram_en[1], ram_we[1], cpu_ready[1]}), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 2'b00, 16'h0020, 16'h0000, 1, 0, 4, 16'h0000, 16'hA5C3);

    repeat (4) @(negedge clk);
    checkOutput("ram_queue_drained", 64'(ram_q.size()), 64'h0);
    checkOutput("ready_queue_drained", 64'(rdy_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reflet_mem_rmw.md
Name: reflet_mem_rmw

Overview:
- Memory access sequencer between the reduced-behaviour data path and the word-wide RAM.
- Turns each CPU load/store into RAM cycles with a fixed read latency.
- Reduced-width stores become read-modify-write sequences; reduced-width loads are zero-extended.
- Presents a single-request / done-pulse handshake to the CPU, so the CPU stalls until `cpu_ready`.

Parameters:
- wordsize, 16: CPU/RAM word width in bits; legal values 8, 16, 32, 64, 128.
- ram_latency, 1: cycles from a read-enabled RAM cycle to valid `ram_rdata`; legal 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (fixed: one clock, asynchronous active-low reset).
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_write  in  1  1 = store, 0 = load.
- cpu_fetch  in  1  instruction fetch; forces full width regardless of `cpu_size`.
- cpu_size  in  2  reduced-behaviour bits: 00 = full word, 01 = 32-bit, 10 = 16-bit, 11 = 8-bit.
- cpu_addr  in  wordsize  word address.
- cpu_wdata  in  wordsize  store data; low bits significant when reduced.
- cpu_rdata  out  wordsize  load result; valid while `cpu_ready` = 1, then held.
- cpu_ready  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM cycle enable.
- ram_we  out  1  RAM write enable; only meaningful with `ram_en`.
- ram_addr  out  wordsize  RAM address.
- ram_wdata  out  wordsize  RAM write data.
- ram_rdata  in  wordsize  RAM read data; valid `ram_latency` cycles after a read cycle.

Behaviour:
- Reset (async, `reset` = 0):
  - state = IDLE.
  - `ram_en`, `ram_we`, `cpu_ready` = 0.
  - `cpu_rdata`, `ram_addr`, `ram_wdata` = 0.
  - Internal latches and the wait counter are cleared.
  - Reset mid-sequence drops `ram_en`/`ram_we` immediately. A pending RMW write is abandoned, and there is no `cpu_ready` for it.
- Effective width:
  - reduced = (`cpu_size` != 00) and (sel width < wordsize) and !`cpu_fetch`.
  - sel width is 32/16/8 for 01/10/11.
  - Otherwise the access is full width.
  - `cpu_size`, `cpu_write`, `cpu_fetch`, `cpu_addr` and `cpu_wdata` are latched on acceptance; later input changes have no effect.
- FSM states: IDLE, RD, WAIT, WR, DONE.
  - IDLE: all outputs low except held `cpu_rdata`. If `cpu_req`=1, latch inputs.
    - Store with full width -> WR.
    - Load, or store with reduced width -> RD.
  - RD (1 cycle): `ram_en`=1, `ram_we`=0, `ram_addr` = latched addr. Load the counter with `ram_latency`-1, then -> WAIT.
  - WAIT: the counter decrements each cycle. In the cycle where the counter is 0, `ram_rdata` is valid and is captured.
    - Load: `cpu_rdata` <= `ram_rdata` masked to the effective width (upper bits 0), then -> DONE.
    - Store: merge buffer <= {`ram_rdata` upper bits, latched `cpu_wdata` low bits}, then -> WR.
    - With `ram_latency`=1 the counter starts at 0, so the capture happens in the first WAIT cycle.
  - WR (1 cycle): `ram_en`=1, `ram_we`=1, `ram_addr` = latched addr.
    - `ram_wdata` = merge buffer for reduced stores, latched `cpu_wdata` for full stores.
    - Then -> DONE.
  - DONE (1 cycle): `cpu_ready`=1, then -> IDLE. `cpu_req` is ignored here; a back-to-back request is accepted in the following IDLE cycle.
- Latency (acceptance edge = cycle 0):
  - Full store: WR in cycle 1, `cpu_ready` in cycle 2.
  - Load: RD in cycle 1, capture in cycle 1+L, `cpu_ready` in cycle 2+L.
  - Reduced store: WR in cycle 2+L, `cpu_ready` in cycle 3+L.
- Stores leave `cpu_rdata` unchanged.
- Only one outstanding access is allowed.
- `ram_addr` and `ram_wdata` hold their last value outside RD/WR; verification checks them only while `ram_en`=1.

Decomposition:
- Shared package/header (next to the existing instruction defines):
  - size encodings: SIZE_FULL, SIZE_32, SIZE_16, SIZE_8;
  - FSM state encodings.
- One combinational sub-module, reflet_lane_merge (params wordsize):
  - Inputs: size, reduced, old word, new word.
  - Outputs: the merged word and the zero-extended masked word.
  - It is shared by the WAIT capture paths.

Test Plan (wordsize=16, ram_latency=2 unless noted):
- Full-width load, addr 0x0040, RAM holds 0xBEEF:
  - `ram_en` in cycle 1 with `ram_we`=0;
  - `cpu_ready` in cycle 4;
  - `cpu_rdata`=0xBEEF.
- Reduced store, size=11, RAM[0x0010]=0xA5C3, `cpu_wdata`=0x1277:
  - read cycle, then write cycle with `ram_wdata`=0xA577;
  - `cpu_ready` in cycle 5.
- Reduced load, size=11, RAM=0xA5C3: `cpu_rdata`=0x00C3. Repeat with size=01 (32 > wordsize), which gives a full access with `cpu_rdata`=0xA5C3.
- Fetch with size=11, RAM=0x1234: `cpu_fetch` overrides the size, so `cpu_rdata`=0x1234. Full store with `cpu_wdata`=0x5678 issues a single write cycle in cycle 1 with no read; `cpu_ready` in cycle 2.
- Sweep ram_latency=1 and 4 with a reduced store: `cpu_ready` at cycles 4 and 7 respectively; the merged data is correct in both.
- Assert `reset` low during WAIT of an RMW:
  - `ram_en`/`ram_we` go low immediately, with no write and no `cpu_ready`;
  - after release the FSM is in IDLE, and the next request completes normally.
